// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, status flags and a multi-cycle
// shift-add multiplier. The result is held stable until the consumer takes it.
module alu_seq #(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_NOT = 3'b100, OP_XOR = 3'b101, OP_SHL = 3'b110, OP_MUL = 3'b111
  } op_t;

  state_t             r_state;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic               w_ovf;
  logic [2*WIDTH-1:0] w_step_acc;
  logic               w_last_step;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);

  assign w_sum  = {1'b0, a} + {1'b0, b};
  // The extra top bit of the widened difference is exactly the unsigned borrow.
  assign w_diff = {1'b0, a} - {1'b0, b};

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (op_t'(op))
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_NOT:  w_res = ~a;
      OP_XOR:  w_res = a ^ b;
      OP_SHL:  w_res = a << b[SHW-1:0];
      default: w_res = '0;
    endcase
  end

  assign w_step_acc  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_last_step = (r_cnt == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      result   <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      neg      <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (op_t'(op) == OP_MUL) begin
              r_mcand  <= {{WIDTH{1'b0}}, a};
              r_mplier <= b;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_state  <= S_BUSY;
            end else begin
              result  <= w_res;
              carry   <= w_carry;
              zero    <= (w_res == '0);
              neg     <= w_res[WIDTH-1];
              ovf     <= w_ovf;
              r_state <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          r_acc    <= w_step_acc;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last_step) begin
            result  <= w_step_acc[WIDTH-1:0];
            carry   <= |w_step_acc[2*WIDTH-1:WIDTH];
            zero    <= (w_step_acc[WIDTH-1:0] == '0);
            neg     <= w_step_acc[WIDTH-1];
            ovf     <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases, randomized operations against
// an arithmetic reference model, backpressure and reset during a multiply.
module tb_alu_seq;

  localparam int WIDTH = 4;
  localparam int SHW   = 2;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             neg;
  logic             ovf;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .neg(neg), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int msb(input int v);
    return (v >> (WIDTH - 1)) & 1;
  endfunction

  // Reference model: plain integer arithmetic on the opcode rules.
  function automatic void model(input int o, input int x, input int y,
                                output int res, output int c, output int v);
    int s;
    c = 0;
    v = 0;
    case (o)
      0: begin
        s   = x + y;
        res = s & MASK;
        c   = (s > MASK) ? 1 : 0;
        v   = (msb(x) == msb(y) && msb(res) != msb(x)) ? 1 : 0;
      end
      1: begin
        res = (x - y) & MASK;
        c   = (x < y) ? 1 : 0;
        v   = (msb(x) != msb(y) && msb(res) != msb(x)) ? 1 : 0;
      end
      2: res = x & y;
      3: res = x | y;
      4: res = (~x) & MASK;
      5: res = x ^ y;
      6: res = (x << (y % (1 << SHW))) & MASK;
      default: begin
        s   = x * y;
        res = s & MASK;
        c   = (s > MASK) ? 1 : 0;
      end
    endcase
  endfunction

  // Issues one operation (called at a negedge with out_ready=1) and checks it end to end.
  task automatic run_op(input int o, input int x, input int y);
    int er, ec, ev, lat;
    string t;
    model(o, x, y, er, ec, ev);
    t = $sformatf("op%0d a=%0d b=%0d", o, x, y);
    check({t, " in_ready_before"}, in_ready, 1);
    in_valid = 1'b1;
    op = 3'(o);
    a  = WIDTH'(x);
    b  = WIDTH'(y);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      check({t, " in_ready_busy"}, in_ready, 0);
      @(negedge clk);
      lat++;
    end
    check({t, " latency"}, lat, (o == 7) ? WIDTH + 1 : 1);
    check({t, " result"}, result, er);
    check({t, " carry"}, carry, ec);
    check({t, " ovf"}, ovf, ev);
    check({t, " zero"}, zero, (er == 0) ? 1 : 0);
    check({t, " neg"}, neg, msb(er));
    check({t, " in_ready_done"}, in_ready, 0);
    @(negedge clk);
    check({t, " out_valid_after"}, out_valid, 0);
    check({t, " in_ready_after"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int seen_valid;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    op = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst result", result, 0);
    check("rst flags", {carry, zero, neg, ovf}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst in_ready", in_ready, 1);
    check("post_rst out_valid", out_valid, 0);

    run_op(0, 4'b0011, 4'b0101);
    run_op(0, 4'b1111, 4'b0001);
    run_op(1, 4'b0110, 4'b0010);
    run_op(1, 4'b0001, 4'b0010);
    run_op(2, 4'b1100, 4'b1010);
    run_op(3, 4'b1100, 4'b1010);
    run_op(5, 4'b1100, 4'b1010);
    run_op(4, 4'b0101, 4'b0000);
    run_op(6, 4'b0011, 4'b0010);
    run_op(7, 4'b0101, 4'b0011);
    run_op(7, 4'b0111, 4'b0011);
    run_op(7, 4'b1111, 4'b1111);
    run_op(7, 4'b0000, 4'b1011);

    for (int i = 0; i < 150; i++)
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)),
             int'($urandom_range(0, MASK)));

    // Backpressure: result held while the consumer stalls, new requests ignored.
    out_ready = 1'b0;
    in_valid = 1'b1;
    op = 3'b000;
    a = 4'b0011;
    b = 4'b0101;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp out_valid", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      op = 3'b001;
      a = 4'b1111;
      b = 4'b1111;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp%0d out_valid", i), out_valid, 1);
      check($sformatf("bp%0d in_ready", i), in_ready, 0);
      check($sformatf("bp%0d result", i), result, 4'b1000);
      check($sformatf("bp%0d flags", i), {carry, zero, neg, ovf}, 4'b0011);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp release in_ready", in_ready, 1);
    check("bp release out_valid", out_valid, 0);
    check("bp held result", result, 4'b1000);

    // Reset during the second BUSY cycle of a multiply.
    in_valid = 1'b1;
    op = 3'b111;
    a = 4'b0101;
    b = 4'b0011;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mulrst busy in_ready", in_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mulrst in_ready", in_ready, 1);
    check("mulrst out_valid", out_valid, 0);
    check("mulrst result", result, 0);
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1;
    end
    check("mulrst no_output", seen_valid, 0);
    run_op(0, 4'b1010, 4'b0110);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
